// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ready bus between the M stage and the data memory.
interface mem_wb_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata;
  logic        dmem_ready;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_rdata, dmem_ready);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_rdata, dmem_ready);
endinterface

// File: rtl/mem_wb_stage.sv
// Y86-64 M stage: data-memory access via req/ready handshake, loads the W register.
// Optional access timeout enabled by defining DMEM_TIMEOUT_EN.
module mem_wb_stage #(
  parameter int ADDR_LIMIT     = 8192,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            M_stat,
  input  logic [3:0]            M_Ins_Code,
  input  logic [3:0]            M_Ins_fun,
  input  logic [63:0]           M_Value_E,
  input  logic [63:0]           M_value_A,
  input  logic [3:0]            M_dstE,
  input  logic [3:0]            M_dstM,
  input  logic                  W_stall,
  mem_wb_stage_if.master        dmem,
  output logic                  m_busy,
  output logic [2:0]            m_stat,
  output logic [2:0]            W_stat,
  output logic [3:0]            W_Ins_Code,
  output logic [63:0]           W_valE,
  output logic [63:0]           W_valM,
  output logic [3:0]            W_dstE,
  output logic [3:0]            W_dstM
);
  localparam logic [63:0] ADDR_MAX = 64'(ADDR_LIMIT - 8);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } wreg_t;

  localparam wreg_t BUBBLE = '{stat: 3'd0, icode: 4'h1, valE: 64'd0,
                               valM: 64'd0, dstE: 4'hF, dstM: 4'hF};

  state_t      state, state_nx;
  wreg_t       w_q, w_nx;
  logic        req_q, we_q;
  logic [63:0] addr_q, wdata_q, valM_q;
  logic        is_rd, is_wr, need, addr_err, go, busy;
  logic [63:0] acc_addr;
  logic        expire, to_flag;

  // ifun does not affect memory access or the W register
  logic unused_ifun;
  assign unused_ifun = ^M_Ins_fun;

  always_comb begin
    is_rd    = (M_Ins_Code == 4'h5) || (M_Ins_Code == 4'h9) || (M_Ins_Code == 4'hB);
    is_wr    = (M_Ins_Code == 4'h4) || (M_Ins_Code == 4'h8) || (M_Ins_Code == 4'hA);
    need     = is_rd || is_wr;
    acc_addr = ((M_Ins_Code == 4'h9) || (M_Ins_Code == 4'hB)) ? M_value_A : M_Value_E;
    addr_err = need && (acc_addr > ADDR_MAX);
    go       = need && (M_stat == 3'd0) && !addr_err;
  end

  assign m_stat = addr_err ? 3'd2 : M_stat;

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] to_cnt;

  // ready on the expiry cycle takes priority and completes normally
  assign expire = (state == WAIT) && !dmem.dmem_ready &&
                  (to_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= 8'd0;
      to_flag <= 1'b0;
    end else if (state == IDLE && go) begin
      to_cnt  <= 8'd0;
      to_flag <= 1'b0;
    end else if (state == WAIT) begin
      to_cnt  <= to_cnt + 8'd1;
      if (expire) to_flag <= 1'b1;
    end
  end
`else
  logic unused_to;
  assign unused_to = ^32'(TIMEOUT_CYCLES);
  assign expire    = 1'b0;
  assign to_flag   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: if (go) begin
        busy     = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (dmem.dmem_ready || expire) state_nx = DONE;
      end
      DONE: if (!W_stall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign m_busy = rst_n & busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      valM_q  <= 64'd0;
    end else if (state == IDLE && go) begin
      req_q   <= 1'b1;
      we_q    <= is_wr;
      addr_q  <= acc_addr;
      wdata_q <= M_value_A;
      valM_q  <= 64'd0;
    end else if (state == WAIT && dmem.dmem_ready) begin
      req_q <= 1'b0;
      if (!we_q) valM_q <= dmem.dmem_rdata;
    end else if (expire) begin
      req_q  <= 1'b0;
      valM_q <= 64'd0;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  always_comb begin
    w_nx = w_q;
    if (!W_stall) begin
      if (m_busy) begin
        w_nx = BUBBLE;
      end else begin
        w_nx.stat  = to_flag ? 3'd2 : m_stat;
        w_nx.icode = M_Ins_Code;
        w_nx.valE  = M_Value_E;
        w_nx.valM  = (state == DONE && is_rd && !to_flag) ? valM_q : 64'd0;
        w_nx.dstE  = M_dstE;
        w_nx.dstM  = M_dstM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_q <= BUBBLE;
    else        w_q <= w_nx;
  end

  assign W_stat     = w_q.stat;
  assign W_Ins_Code = w_q.icode;
  assign W_valE     = w_q.valE;
  assign W_valM     = w_q.valM;
  assign W_dstE     = w_q.dstE;
  assign W_dstM     = w_q.dstM;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; timeout case runs when DMEM_TIMEOUT_EN is defined.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  M_stat;
  logic [3:0]  M_Ins_Code, M_Ins_fun, M_dstE, M_dstM;
  logic [63:0] M_Value_E, M_value_A;
  logic        W_stall;
  logic        m_busy;
  logic [2:0]  m_stat, W_stat;
  logic [3:0]  W_Ins_Code, W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  int          checks = 0;
  int          errors = 0;

  mem_wb_stage_if dif();

  mem_wb_stage #(.ADDR_LIMIT(8192), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_stat(M_stat), .M_Ins_Code(M_Ins_Code), .M_Ins_fun(M_Ins_fun),
    .M_Value_E(M_Value_E), .M_value_A(M_value_A),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall),
    .dmem(dif), .m_busy(m_busy), .m_stat(m_stat),
    .W_stat(W_stat), .W_Ins_Code(W_Ins_Code), .W_valE(W_valE),
    .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_m(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
    M_stat = st; M_Ins_Code = ic; M_Value_E = ve; M_value_A = va; M_dstE = de; M_dstM = dm;
  endtask

  initial begin
    rst_n = 1'b0; W_stall = 1'b0; M_Ins_fun = 4'h0;
    dif.dmem_ready = 1'b0; dif.dmem_rdata = 64'd0;
    set_m(3'd0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
    tick(); tick();
    chk("rst_W_icode", 64'(W_Ins_Code), 64'h1);
    chk("rst_W_dstE", 64'(W_dstE), 64'hF);
    chk("rst_W_dstM", 64'(W_dstM), 64'hF);
    chk("rst_req", 64'(dif.dmem_req), 64'd0);
    chk("rst_busy", 64'(m_busy), 64'd0);
    rst_n = 1'b1;

    // OPq: one-edge latency, stray ready in IDLE ignored
    set_m(3'd0, 4'h6, 64'h2A, 64'h0, 4'd3, 4'hF);
    dif.dmem_ready = 1'b1; dif.dmem_rdata = 64'h1234;
    #1 chk("op_busy_comb", 64'(m_busy), 64'd0);
    chk("op_mstat", 64'(m_stat), 64'd0);
    tick();
    dif.dmem_ready = 1'b0;
    chk("op_W_valE", W_valE, 64'h2A);
    chk("op_W_dstE", 64'(W_dstE), 64'd3);
    chk("op_W_stat", 64'(W_stat), 64'd0);
    chk("op_W_icode", 64'(W_Ins_Code), 64'h6);
    chk("op_W_valM", W_valM, 64'd0);
    chk("op_busy", 64'(m_busy), 64'd0);

    // mrmovq: ready on the 3rd WAIT cycle
    set_m(3'd0, 4'h5, 64'h100, 64'h0, 4'hF, 4'd4);
    #1 chk("rd_busy_idle", 64'(m_busy), 64'd1);
    chk("rd_req_idle", 64'(dif.dmem_req), 64'd0);
    tick();
    chk("rd_req1", 64'(dif.dmem_req), 64'd1);
    chk("rd_addr", dif.dmem_addr, 64'h100);
    chk("rd_we", 64'(dif.dmem_we), 64'd0);
    chk("rd_W_bubble", 64'(W_Ins_Code), 64'h1);
    tick();
    chk("rd_req2", 64'(dif.dmem_req), 64'd1);
    chk("rd_busy2", 64'(m_busy), 64'd1);
    tick();
    chk("rd_req3", 64'(dif.dmem_req), 64'd1);
    dif.dmem_ready = 1'b1; dif.dmem_rdata = 64'hDEAD;
    tick();
    dif.dmem_ready = 1'b0; dif.dmem_rdata = 64'h0;
    chk("rd_req_done", 64'(dif.dmem_req), 64'd0);
    chk("rd_busy_done", 64'(m_busy), 64'd0);
    chk("rd_W_still_bubble", 64'(W_dstM), 64'hF);
    tick();
    chk("rd_W_valM", W_valM, 64'hDEAD);
    chk("rd_W_dstM", 64'(W_dstM), 64'd4);
    chk("rd_W_icode", 64'(W_Ins_Code), 64'h5);
    chk("rd_W_stat", 64'(W_stat), 64'd0);

    // pushq with W_stall held one cycle in DONE
    set_m(3'd0, 4'hA, 64'h1F8, 64'h55, 4'd4, 4'hF);
    #1 chk("wr_busy_idle", 64'(m_busy), 64'd1);
    tick();
    chk("wr_we", 64'(dif.dmem_we), 64'd1);
    chk("wr_addr", dif.dmem_addr, 64'h1F8);
    chk("wr_wdata", dif.dmem_wdata, 64'h55);
    chk("wr_req", 64'(dif.dmem_req), 64'd1);
    dif.dmem_ready = 1'b1; dif.dmem_rdata = 64'hBEEF;
    tick();
    dif.dmem_ready = 1'b0;
    chk("wr_req_done", 64'(dif.dmem_req), 64'd0);
    W_stall = 1'b1;
    tick();
    chk("wr_stall_hold", 64'(W_Ins_Code), 64'h1);
    chk("wr_stall_busy", 64'(m_busy), 64'd0);
    W_stall = 1'b0;
    tick();
    chk("wr_W_valM", W_valM, 64'd0);
    chk("wr_W_valE", W_valE, 64'h1F8);
    chk("wr_W_icode", 64'(W_Ins_Code), 64'hA);
    chk("wr_W_dstE", 64'(W_dstE), 64'd4);

    // address boundary and status gating
    set_m(3'd0, 4'h4, 64'h1FF8, 64'h0, 4'hF, 4'hF);
    #1 chk("lim_ok_busy", 64'(m_busy), 64'd1);
    chk("lim_ok_mstat", 64'(m_stat), 64'd0);
    set_m(3'd0, 4'h9, 64'h0, 64'h3000, 4'd4, 4'hF);
    #1 chk("ret_valA_adr", 64'(m_stat), 64'd2);
    set_m(3'd1, 4'h5, 64'h40, 64'h0, 4'hF, 4'd2);
    #1 chk("hlt_busy", 64'(m_busy), 64'd0);
    chk("hlt_mstat", 64'(m_stat), 64'd1);
    set_m(3'd0, 4'h4, 64'h2000, 64'h7, 4'hF, 4'hF);
    #1 chk("adr_mstat", 64'(m_stat), 64'd2);
    chk("adr_busy", 64'(m_busy), 64'd0);
    tick();
    chk("adr_W_stat", 64'(W_stat), 64'd2);
    chk("adr_W_icode", 64'(W_Ins_Code), 64'h4);
    chk("adr_req", 64'(dif.dmem_req), 64'd0);

    // popq interrupted by reset in WAIT
    set_m(3'd0, 4'hB, 64'h0, 64'h80, 4'd4, 4'd5);
    tick();
    chk("rst_wait_req", 64'(dif.dmem_req), 64'd1);
    chk("rst_wait_addr", dif.dmem_addr, 64'h80);
    #2 rst_n = 1'b0;
    set_m(3'd0, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    #1 chk("rst_mid_req", 64'(dif.dmem_req), 64'd0);
    chk("rst_mid_busy", 64'(m_busy), 64'd0);
    chk("rst_mid_W", 64'(W_Ins_Code), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    dif.dmem_ready = 1'b1; dif.dmem_rdata = 64'hCAFE;
    tick();
    dif.dmem_ready = 1'b0;
    chk("late_rdy_req", 64'(dif.dmem_req), 64'd0);
    chk("late_rdy_busy", 64'(m_busy), 64'd0);
    chk("late_rdy_valM", W_valM, 64'd0);
    chk("late_rdy_dstM", 64'(W_dstM), 64'hF);

`ifdef DMEM_TIMEOUT_EN
    // no ready: request drops after 4 WAIT cycles
    set_m(3'd0, 4'h5, 64'h40, 64'h0, 4'hF, 4'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), 64'(dif.dmem_req), 64'd1);
      tick();
    end
    chk("to_req_drop", 64'(dif.dmem_req), 64'd0);
    chk("to_busy", 64'(m_busy), 64'd0);
    tick();
    chk("to_W_stat", 64'(W_stat), 64'd2);
    chk("to_W_valM", W_valM, 64'd0);
    chk("to_W_icode", 64'(W_Ins_Code), 64'h5);
    set_m(3'd0, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
